// File: rtl/cla_pkg.sv
// Shared definitions for the 28-bit CLA accumulator slice.
package cla_pkg;
  localparam int CLA_W       = 28;
  localparam int COUNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/cla28_accumulator_if.sv
// Burst control, operand stream and result stream of the accumulator.
interface cla28_accumulator_if
  import cla_pkg::*;
#(
  parameter int WIDTH   = CLA_W,
  parameter int COUNT_W = COUNT_W_DEF
);
  logic               start;
  logic [COUNT_W-1:0] len;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic               out_wrap;
  logic [COUNT_W-1:0] out_count;
  logic               busy;

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_wrap, out_count, busy
  );

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_wrap, out_count, busy
  );
endinterface

// File: rtl/cla28_accumulator_cla.sv
// 28-bit carry-lookahead adder: seven 4-bit lookahead groups, with the
// group carries resolved from group generate/propagate terms.
module CLA28bit
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] A,
  input  logic [CLA_W-1:0] B,
  output logic [CLA_W-1:0] S
);
  localparam int NGRP = CLA_W / 4;

  logic [CLA_W-1:0] w_g;
  logic [CLA_W-1:0] w_p;
  logic [CLA_W-1:0] w_c;
  logic [NGRP-1:0]  w_grp_g;
  logic [NGRP-1:0]  w_grp_p;
  logic [NGRP-1:0]  w_grp_cin;

  assign w_g = A & B;
  assign w_p = A ^ B;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [3:0] w_lg;
      logic [3:0] w_lp;
      logic       w_ci;
      assign w_lg = w_g[gi*4 +: 4];
      assign w_lp = w_p[gi*4 +: 4];
      assign w_ci = w_grp_cin[gi];
      assign w_c[gi*4 + 0] = w_ci;
      assign w_c[gi*4 + 1] = w_lg[0] | (w_lp[0] & w_ci);
      assign w_c[gi*4 + 2] = w_lg[1] | (w_lp[1] & w_lg[0]) | (w_lp[1] & w_lp[0] & w_ci);
      assign w_c[gi*4 + 3] = w_lg[2] | (w_lp[2] & w_lg[1]) | (w_lp[2] & w_lp[1] & w_lg[0])
                           | (w_lp[2] & w_lp[1] & w_lp[0] & w_ci);
      assign w_grp_g[gi] = w_lg[3] | (w_lp[3] & w_lg[2]) | (w_lp[3] & w_lp[2] & w_lg[1])
                         | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);
      assign w_grp_p[gi] = &w_lp;
    end
  endgenerate

  // Group-level carry chain; carry into the LSB group is zero.
  always_comb begin
    logic v_c;
    v_c       = 1'b0;
    w_grp_cin = '0;
    for (int k = 0; k < NGRP; k++) begin
      w_grp_cin[k] = v_c;
      v_c          = w_grp_g[k] | (w_grp_p[k] & v_c);
    end
  end

  assign S = w_p ^ w_c;
endmodule

// File: rtl/cla28_accumulator.sv
// Burst accumulator: sums a programmed number of operands through CLA28bit
// and offers the sum, sticky wrap flag and beat count on a result handshake.
module cla28_accumulator
  import cla_pkg::*;
#(
  parameter int WIDTH   = CLA_W,
  parameter int COUNT_W = COUNT_W_DEF
)(
  input  logic                clk,
  input  logic                rst,
  cla28_accumulator_if.slave  bus
);
  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_sum;
  logic               r_wrap;
  logic [COUNT_W-1:0] r_remaining;
  logic [COUNT_W-1:0] r_count;
  logic               w_fire;
  logic               w_load;

  assign w_fire = (r_state == ACCUM) && bus.in_valid;
  assign w_load = (r_state == IDLE) && bus.start;

  CLA28bit u_cla (
    .A (r_acc),
    .B (bus.in_data),
    .S (w_sum)
  );

  // Next-state selection.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = (bus.len == '0) ? DONE : ACCUM;
      ACCUM:   if (w_fire && (r_remaining == COUNT_W'(1))) w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Accumulator, sticky wrap and beat counters; a sum smaller than the old
  // accumulator means the add carried out of bit 27.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_wrap      <= 1'b0;
      r_remaining <= '0;
      r_count     <= '0;
    end else if (w_load) begin
      r_acc       <= '0;
      r_wrap      <= 1'b0;
      r_remaining <= bus.len;
      r_count     <= '0;
    end else if (w_fire) begin
      r_acc       <= w_sum;
      r_wrap      <= r_wrap | (w_sum < r_acc);
      r_remaining <= r_remaining - COUNT_W'(1);
      r_count     <= r_count + COUNT_W'(1);
    end
  end

  assign bus.in_ready  = (r_state == ACCUM);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == ACCUM) || (r_state == DONE);
  assign bus.out_sum   = r_acc;
  assign bus.out_wrap  = r_wrap;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_cla28_accumulator.sv
// Self-checking bench for cla28_accumulator: a burst-level reference model
// checked every cycle, plus directed bursts with literal expectations.
module tb_cla28_accumulator;
  localparam int W  = 28;
  localparam int CW = 8;
  localparam longint MOD = 64'd1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla28_accumulator_if #(.WIDTH(W), .COUNT_W(CW)) bus();
  cla28_accumulator #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 accumulating, 2 result offered.
  // The exact (unbounded) total is kept; since operands are unsigned, some
  // add wrapped exactly when the true total reaches 2**28.
  int     m_phase = 0;
  int     m_rem   = 0;
  int     m_count = 0;
  longint m_total = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_rem = 0; m_count = 0; m_total = 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
             m_total = 0; m_count = 0; m_rem = int'(bus.len);
             m_phase = (bus.len == 0) ? 2 : 1;
           end
        1: if (bus.in_valid) begin
             m_total += longint'(bus.in_data);
             m_count++; m_rem--;
             if (m_rem == 0) m_phase = 2;
           end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
    #1;
    check("in_ready",  bus.in_ready,  64'(m_phase == 1));
    check("out_valid", bus.out_valid, 64'(m_phase == 2));
    check("busy",      bus.busy,      64'(m_phase != 0));
    if (m_phase != 1) begin
      check("out_sum",   bus.out_sum,   64'(m_total % MOD));
      check("out_wrap",  bus.out_wrap,  64'(m_total >= MOD));
      check("out_count", bus.out_count, 64'(m_count));
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic feed(input logic [W-1:0] d, input int gap);
    bit taken = 0;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 50; t++) begin
      if (bus.in_ready) begin taken = 1; break; end
      @(negedge clk);
    end
    if (!taken) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_burst(input int l, input logic [W-1:0] ops[$], input int maxgap,
                           input int hold, input bit start_on_accept,
                           output logic [W-1:0] r_sum, output logic r_wrap,
                           output logic [CW-1:0] r_cnt);
    bit seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = CW'(l);
    @(negedge clk);
    bus.start = 1'b0;
    foreach (ops[i]) feed(ops[i], (i == 0 || maxgap == 0) ? 0 : $urandom_range(0, maxgap));
    bus.in_valid = 1'b0;
    if (l > 0) check("latency_out_valid", bus.out_valid, 1);
    for (int t = 0; t < 50; t++) begin
      if (bus.out_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) check("out_valid_timeout", 0, 1);
    r_sum  = bus.out_sum;
    r_wrap = bus.out_wrap;
    r_cnt  = bus.out_count;
    bus.out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_sum",   bus.out_sum,   r_sum);
      check("hold_wrap",  bus.out_wrap,  r_wrap);
      check("hold_count", bus.out_count, r_cnt);
    end
    bus.out_ready = 1'b1;
    if (start_on_accept) begin
      bus.start = 1'b1;
      bus.len   = CW'($urandom_range(1, 5));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("idle_after_accept", {bus.out_valid, bus.busy}, 2'b00);
  endtask

  logic [W-1:0]  q[$];
  logic [W-1:0]  s;
  logic          wr;
  logic [CW-1:0] c;

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy",      bus.busy,      0);
    check("rst_out_sum",   bus.out_sum,   0);
    check("rst_out_wrap",  bus.out_wrap,  0);
    check("rst_out_count", bus.out_count, 0);

    // Basic back-to-back burst.
    q = {28'd1, 28'd2, 28'd3};
    run_burst(3, q, 0, 0, 0, s, wr, c);
    check("basic_sum", s, 6); check("basic_wrap", wr, 0); check("basic_count", c, 3);

    // Wrap past 2**28-1.
    q = {28'hFFFFFFF, 28'h0000002};
    run_burst(2, q, 0, 0, 0, s, wr, c);
    check("wrap_sum", s, 1); check("wrap_flag", wr, 1); check("wrap_count", c, 2);

    // Input gaps and five cycles of result backpressure.
    q = {28'd10, 28'd20, 28'd30, 28'd40};
    run_burst(4, q, 3, 5, 0, s, wr, c);
    check("gap_sum", s, 100); check("gap_wrap", wr, 0); check("gap_count", c, 4);

    // Zero-length burst, with a start during the accept that must be ignored.
    q = {};
    run_burst(0, q, 0, 1, 1, s, wr, c);
    check("len0_sum", s, 0); check("len0_count", c, 0); check("len0_wrap", wr, 0);

    // Reset in the middle of a burst.
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    feed(28'd100, 0);
    feed(28'd200, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_busy",      bus.busy,      0);
    end
    q = {28'd7};
    run_burst(1, q, 0, 0, 0, s, wr, c);
    check("midrst_sum", s, 7); check("midrst_count", c, 1);

    // Longest burst: 255 maximal operands.
    q = {};
    for (int i = 0; i < 255; i++) q.push_back(28'hFFFFFFF);
    run_burst(255, q, 0, 0, 0, s, wr, c);
    check("long_sum", s, 28'hFFFFF01); check("long_wrap", wr, 1); check("long_count", c, 255);

    // Randomized bursts, checked by the model.
    for (int b = 0; b < 40; b++) begin
      int l;
      l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      q = {};
      for (int i = 0; i < l; i++) begin
        case ($urandom_range(0, 2))
          0:       q.push_back(28'hFFFFFFF - W'($urandom_range(0, 15)));
          1:       q.push_back(W'($urandom_range(0, 255)));
          default: q.push_back(W'($urandom));
        endcase
      end
      run_burst(l, q, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), s, wr, c);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
